wptr_full_level: RTL and testbench
==================================

# wptr_full_level

Write-domain pointer and status block for the dual-clock FIFO. It generalises the write-pointer/full logic with an occupancy count, a run-time almost-full threshold, a write-accept strobe and a sticky overflow flag. It sits in the wclk domain next to the FIFO RAM write port. It consumes the 2-flop-synchronised Gray read pointer and produces the Gray write pointer for the read-side synchroniser.

## Interface
- ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH entries (minimum ADDR_WIDTH = 2)
- wclk  input  1  write-domain clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset for all state in this block
- winc  input  1  write request for the current cycle
- rptr_sync  input  ADDR_WIDTH+1  Gray read pointer, already synchronised into wclk
- afull_thresh  input  ADDR_WIDTH+1  almost-full level, 0..DEPTH, quasi-static
- ovf_clr  input  1  clears the sticky overflow flag
- wen  output  1  combinational; asserted when winc is high and full is low; drives the RAM write enable
- waddr  output  ADDR_WIDTH  RAM write address, equal to wbin[ADDR_WIDTH-1:0]
- wptr  output  ADDR_WIDTH+1  registered Gray write pointer
- full  output  1  registered full flag
- almost_full  output  1  registered flag; high when wlevel >= afull_thresh
- wlevel  output  ADDR_WIDTH+1  registered write-side occupancy, 0..DEPTH
- overflow  output  1  sticky flag; set by a write attempt while full

## Operation
- State registers: wbin (binary, ADDR_WIDTH+1), wgray, full, almost_full, wlevel, overflow.
- Next-state arithmetic:
  - wen = winc & ~full.
  - wbin_next = wbin + wen, mod 2**(ADDR_WIDTH+1).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
  - wptr = wgray, and wgray <= wgray_next every cycle.
- Read pointer conversion: rbin_sync is the Gray-to-binary conversion of rptr_sync. The MSB is copied; each lower bit is the XOR of the bit above it in rbin_sync and the corresponding rptr_sync bit. The conversion is purely combinational.
- Occupancy: wlevel_next = wbin_next - rbin_sync, mod 2**(ADDR_WIDTH+1). The result is always 0..DEPTH for legal input.
- Full: full <= (wgray_next == {~rptr_sync[AW:AW-1], rptr_sync[AW-2:0]}). This is equivalent to wlevel_next == DEPTH, and both forms must agree.
- Almost full: almost_full <= (wlevel_next >= afull_thresh).
  - The comparison is unsigned.
  - afull_thresh = 0 forces almost_full high.
  - afull_thresh = DEPTH makes almost_full track full.
  - Any value above DEPTH keeps almost_full low.
- Overflow:
  - overflow <= (overflow & ~ovf_clr) | (winc & full).
  - If ovf_clr and a new overflow event occur in the same cycle, the set wins.
  - A rejected write does not change wbin, waddr or the RAM.
- Pessimism: a stale rptr_sync only over-reports occupancy. full and almost_full may deassert late but never deassert early.
- Wrap-around: wbin rolls from 2**(ADDR_WIDTH+1)-1 to 0 with no special handling. The wrap bit (MSB) distinguishes full from empty.

## Timing
- Reset (rst_n low, asynchronous): wbin = 0, wptr = 0, waddr = 0, full = 0, almost_full = (afull_thresh == 0) after the first clock, wlevel = 0, overflow = 0. Outputs reach these values immediately on reset assertion, except almost_full as noted. Reset release is synchronous to wclk, handled externally.
- Reset mid-operation: all pointers return to 0 in the same instant. The read side must be reset together with this block; this block does no recovery.
- Write latency: an accepted write at edge N updates waddr, wptr and wlevel from edge N. full and almost_full reflect that write at edge N, with no extra cycle.
- wen is combinational from winc and registered full. It is valid in the same cycle as winc.
- Read-side credit is visible only once rptr_sync changes. wlevel and flags update at the first wclk edge after the change.
- Each cycle wptr changes by at most one bit (Gray property). This is required for safe CDC.

## Test plan
- Reset, then 16 writes with rptr_sync = 0 (ADDR_WIDTH = 4) -> wlevel counts 1..16; full goes high on the 16th edge; waddr = 0 and wptr = 5'b11000 after the 16th write.
- Full, then a 17th winc -> wen = 0; waddr, wptr and wlevel unchanged; overflow = 1 next edge. ovf_clr with winc still high and full -> overflow stays 1. ovf_clr with winc low -> overflow = 0.
- afull_thresh = 12, rptr_sync = 0, write 12 -> almost_full rises on the 12th write edge. Then step rptr_sync to Gray(1) -> almost_full clears and wlevel = 11 one edge later.
- Wrap: drive 40 writes with rptr_sync tracking Gray(wbin - 3) -> wbin passes 31 to 0; wlevel stays 3; full never asserts; every wptr step differs by exactly 1 bit.
- Simultaneous: at full, rptr_sync advances by one in the same cycle as winc -> at that edge full clears and no write is taken. Next edge the write is accepted and full sets again.
- Async reset asserted mid-burst between clock edges -> all outputs read 0 before the next wclk edge.

Source files
------------

// File: rtl/wptr_full_level_if.sv
// Write-side handshake and status bundle for the dual-clock FIFO write pointer block.
// master = write requester / observer, slave = wptr_full_level.
`timescale 1ns/1ps
interface wptr_full_level_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  winc;
    logic [ADDR_WIDTH:0]   rptr_sync;
    logic [ADDR_WIDTH:0]   afull_thresh;
    logic                  ovf_clr;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   wptr;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wlevel;
    logic                  overflow;

    modport master (
        output winc, rptr_sync, afull_thresh, ovf_clr,
        input  wen, waddr, wptr, full, almost_full, wlevel, overflow
    );

    modport slave (
        input  winc, rptr_sync, afull_thresh, ovf_clr,
        output wen, waddr, wptr, full, almost_full, wlevel, overflow
    );
endinterface

// File: rtl/wptr_full_level.sv
// Write-domain pointer, occupancy, almost-full and sticky overflow for a dual-clock FIFO.
// Latency: wen combinational; pointer, level and flags registered, reflecting a write at its own edge.
// Backpressure: writes are refused while full; a refused write sets overflow and leaves state untouched.
`timescale 1ns/1ps
module wptr_full_level #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic              wclk,
    input  logic              rst_n,
    wptr_full_level_if.slave  bus
);
    localparam int AW = ADDR_WIDTH;

    logic [AW:0] wbin;
    logic [AW:0] wgray;
    logic [AW:0] wlevel_q;
    logic        full_q;
    logic        afull_q;
    logic        ovf_q;

    logic        wen;
    logic [AW:0] wbin_next;
    logic [AW:0] wgray_next;
    logic [AW:0] rbin_sync;
    logic [AW:0] wlevel_next;
    logic        full_next;
    logic        afull_next;

    always_comb begin
        wen        = bus.winc & ~full_q;
        wbin_next  = wbin + {{AW{1'b0}}, wen};
        wgray_next = (wbin_next >> 1) ^ wbin_next;

        // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
        rbin_sync = '0;
        for (int i = 0; i <= AW; i++) begin
            rbin_sync[i] = ^(bus.rptr_sync >> i);
        end

        wlevel_next = wbin_next - rbin_sync;
        // Full when the write pointer has lapped the read pointer by exactly one wrap.
        full_next   = (wgray_next == {~bus.rptr_sync[AW:AW-1], bus.rptr_sync[AW-2:0]});
        afull_next  = (wlevel_next >= bus.afull_thresh);
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wbin     <= '0;
            wgray    <= '0;
            wlevel_q <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wbin     <= wbin_next;
            wgray    <= wgray_next;
            wlevel_q <= wlevel_next;
            full_q   <= full_next;
            afull_q  <= afull_next;
            ovf_q    <= (ovf_q & ~bus.ovf_clr) | (bus.winc & full_q);
        end
    end

    assign bus.wen         = wen;
    assign bus.waddr       = wbin[AW-1:0];
    assign bus.wptr        = wgray;
    assign bus.full        = full_q;
    assign bus.almost_full = afull_q;
    assign bus.wlevel      = wlevel_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_wptr_full_level.sv
// Directed bench for wptr_full_level with ADDR_WIDTH = 4 (DEPTH = 16).
`timescale 1ns/1ps
module tb_wptr_full_level;
    localparam int AW = 4;

    logic wclk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    wptr_full_level_if #(.ADDR_WIDTH(AW)) bus ();

    wptr_full_level #(.ADDR_WIDTH(AW)) dut (
        .wclk  (wclk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 wclk = ~wclk;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        bus.winc = 1'b0;
        bus.ovf_clr = 1'b0;
        bus.rptr_sync = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.winc = 1'b0;
        bus.ovf_clr = 1'b0;
        bus.rptr_sync = '0;
        bus.afull_thresh = 5'd16;
        rst_n = 1'b0;
        #3;
        checks++; if (bus.wptr !== 5'd0) begin errors++; $display("FAIL reset_wptr: got %b expected 00000", bus.wptr); end
        checks++; if (bus.waddr !== 4'd0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", bus.waddr); end
        checks++; if (bus.wlevel !== 5'd0) begin errors++; $display("FAIL reset_wlevel: got %0d expected 0", bus.wlevel); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
        checks++; if (bus.wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b expected 0", bus.wen); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        bus.afull_thresh = 5'd16;
        bus.rptr_sync = '0;
        for (int i = 1; i <= 16; i++) begin
            bus.winc = 1'b1;
            #1;
            checks++; if (bus.wen !== 1'b1) begin errors++; $display("FAIL fill_wen[%0d]: got %b expected 1", i, bus.wen); end
            step();
            checks++; if (bus.wlevel !== 5'(i)) begin errors++; $display("FAIL fill_wlevel[%0d]: got %0d expected %0d", i, bus.wlevel, i); end
            checks++; if (bus.full !== (i == 16)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, bus.full, (i == 16)); end
            checks++; if (bus.almost_full !== (i == 16)) begin errors++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, bus.almost_full, (i == 16)); end
            checks++; if (bus.waddr !== 4'(i % 16)) begin errors++; $display("FAIL fill_waddr[%0d]: got %0d expected %0d", i, bus.waddr, i % 16); end
            checks++; if (bus.wptr !== gray(5'(i))) begin errors++; $display("FAIL fill_wptr[%0d]: got %b expected %b", i, bus.wptr, gray(5'(i))); end
        end
        checks++; if (bus.wptr !== 5'b11000) begin errors++; $display("FAIL fill_wptr_final: got %b expected 11000", bus.wptr); end
    endtask

    task automatic test_overflow();
        bus.winc = 1'b1;
        #1;
        checks++; if (bus.wen !== 1'b0) begin errors++; $display("FAIL ovf_wen: got %b expected 0", bus.wen); end
        step();
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.overflow); end
        checks++; if (bus.waddr !== 4'd0) begin errors++; $display("FAIL ovf_waddr: got %0d expected 0", bus.waddr); end
        checks++; if (bus.wptr !== 5'b11000) begin errors++; $display("FAIL ovf_wptr: got %b expected 11000", bus.wptr); end
        checks++; if (bus.wlevel !== 5'd16) begin errors++; $display("FAIL ovf_wlevel: got %0d expected 16", bus.wlevel); end
        bus.ovf_clr = 1'b1;
        step();
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", bus.overflow); end
        bus.winc = 1'b0;
        step();
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow); end
        bus.ovf_clr = 1'b0;
    endtask

    task automatic test_simultaneous();
        bus.winc = 1'b1;
        bus.rptr_sync = gray(5'd1);
        #1;
        checks++; if (bus.wen !== 1'b0) begin errors++; $display("FAIL sim_wen_blocked: got %b expected 0", bus.wen); end
        step();
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL sim_full_clear: got %b expected 0", bus.full); end
        checks++; if (bus.wlevel !== 5'd15) begin errors++; $display("FAIL sim_wlevel15: got %0d expected 15", bus.wlevel); end
        checks++; if (bus.wptr !== 5'b11000) begin errors++; $display("FAIL sim_wptr_hold: got %b expected 11000", bus.wptr); end
        checks++; if (bus.wen !== 1'b1) begin errors++; $display("FAIL sim_wen_open: got %b expected 1", bus.wen); end
        step();
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL sim_full_again: got %b expected 1", bus.full); end
        checks++; if (bus.wlevel !== 5'd16) begin errors++; $display("FAIL sim_wlevel16: got %0d expected 16", bus.wlevel); end
        checks++; if (bus.wptr !== 5'b11001) begin errors++; $display("FAIL sim_wptr: got %b expected 11001", bus.wptr); end
        bus.winc = 1'b0;
    endtask

    task automatic test_almost_full();
        do_reset();
        bus.afull_thresh = 5'd12;
        for (int i = 1; i <= 12; i++) begin
            bus.winc = 1'b1;
            step();
            checks++; if (bus.almost_full !== (i >= 12)) begin errors++; $display("FAIL afull_rise[%0d]: got %b expected %b", i, bus.almost_full, (i >= 12)); end
        end
        bus.winc = 1'b0;
        bus.rptr_sync = gray(5'd1);
        step();
        checks++; if (bus.wlevel !== 5'd11) begin errors++; $display("FAIL afull_wlevel11: got %0d expected 11", bus.wlevel); end
        checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL afull_clear: got %b expected 0", bus.almost_full); end
        bus.afull_thresh = 5'd0;
        step();
        checks++; if (bus.almost_full !== 1'b1) begin errors++; $display("FAIL afull_thresh0: got %b expected 1", bus.almost_full); end
        bus.afull_thresh = 5'd17;
        step();
        checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL afull_thresh17: got %b expected 0", bus.almost_full); end
        bus.afull_thresh = 5'd11;
        step();
        checks++; if (bus.almost_full !== 1'b1) begin errors++; $display("FAIL afull_thresh_eq: got %b expected 1", bus.almost_full); end
    endtask

    task automatic test_wrap();
        logic [4:0] b;
        logic [4:0] prev;
        do_reset();
        bus.afull_thresh = 5'd16;
        for (int i = 0; i < 3; i++) begin
            bus.winc = 1'b1;
            step();
        end
        b = 5'd3;
        prev = bus.wptr;
        for (int i = 0; i < 40; i++) begin
            bus.winc = 1'b1;
            bus.rptr_sync = gray(b - 5'd2);
            step();
            b = b + 5'd1;
            checks++; if (bus.wlevel !== 5'd3) begin errors++; $display("FAIL wrap_wlevel[%0d]: got %0d expected 3", i, bus.wlevel); end
            checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL wrap_full[%0d]: got %b expected 0", i, bus.full); end
            checks++; if (bus.wptr !== gray(b)) begin errors++; $display("FAIL wrap_wptr[%0d]: got %b expected %b", i, bus.wptr, gray(b)); end
            checks++; if ($countones(bus.wptr ^ prev) != 1) begin errors++; $display("FAIL wrap_gray_step[%0d]: got %0d bits changed expected 1", i, $countones(bus.wptr ^ prev)); end
            prev = bus.wptr;
        end
        bus.winc = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.afull_thresh = 5'd16;
        for (int i = 0; i < 5; i++) begin
            bus.winc = 1'b1;
            step();
        end
        checks++; if (bus.wlevel !== 5'd5) begin errors++; $display("FAIL arst_pre_wlevel: got %0d expected 5", bus.wlevel); end
        #2;
        bus.winc = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.wptr !== 5'd0) begin errors++; $display("FAIL arst_wptr: got %b expected 00000", bus.wptr); end
        checks++; if (bus.waddr !== 4'd0) begin errors++; $display("FAIL arst_waddr: got %0d expected 0", bus.waddr); end
        checks++; if (bus.wlevel !== 5'd0) begin errors++; $display("FAIL arst_wlevel: got %0d expected 0", bus.wlevel); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL arst_full: got %b expected 0", bus.full); end
        checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL arst_afull: got %b expected 0", bus.almost_full); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL arst_overflow: got %b expected 0", bus.overflow); end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_simultaneous();
        test_almost_full();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
